seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Unsigned radix-2 shift-add sequential multiplier. Takes two WIDTH-bit operands on a one-cycle start pulse and produces a 2*WIDTH-bit product after WIDTH iteration cycles. It uses a ready/start handshake. It is a small arithmetic leaf block for controllers that can tolerate multi-cycle latency in exchange for low area.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH bits; the default build is 16x16 -> 32.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to begin a multiplication; sampled only when ready=1
multiplicand  input  WIDTH  operand A, unsigned; sampled on the accepted start edge
multiplier  input  WIDTH  operand B, unsigned; sampled on the accepted start edge
product  output  2*WIDTH  registered result; holds the last completed product
ready  output  1  1 = idle and able to accept start, and product is valid; 0 = busy

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it is sampled on the clk rising edge.
- Reset values: product=0, ready=1, state=IDLE, iteration counter=0, internal registers=0.
- States:
  - IDLE: ready=1.
  - BUSY: ready=0.
- IDLE -> BUSY on an edge where start=1 and reset=0. On that edge (E0):
  - latch multiplicand into the A register, zero-extended to 2*WIDTH;
  - latch multiplier into the B register;
  - clear the accumulator and counter;
  - set ready to 0.
- BUSY performs one iteration per edge (E1..E_WIDTH):
  - if B[0]=1, acc <= acc + A;
  - A <= A << 1; B <= B >> 1; counter++.
  - All arithmetic is 2*WIDTH wide with no overflow possible.
- On the WIDTH-th iteration edge:
  - product <= the final accumulator value, including that iteration's add;
  - ready <= 1; state returns to IDLE.
- Latency: ready and product are valid WIDTH edges after the start edge (16 for the default). An early exit when B becomes 0 is not used; latency is fixed.
- product changes only on completion edges and on reset. It holds its value during BUSY and across idle periods.
- start while BUSY is ignored; no queueing.
- start held high in IDLE starts a new operation on every edge where ready=1.
  - On the completion edge, ready is still 0, so a start on that edge is ignored.
  - The earliest back-to-back start is on the edge after ready rises.
- Operand inputs may change freely during BUSY without effect.
- Reset mid-operation aborts immediately: product=0, ready=1, IDLE on the next edge.
- Reset has priority over start on the same edge.
- No X propagation: all registers have defined reset values.

Decomposition:
- Shared package seq_mult_pkg holds:
  - the state enum (IDLE, BUSY);
  - the default WIDTH localparam;
  - the counter width, $clog2(WIDTH)+1.
- One sub-module is natural: seq_mult_datapath, containing the A/B shift registers, accumulator adder and product register, driven by load/step/done controls.
- FSM and counter stay in seq_multiplier.

Test Plan:
- Reset then idle: hold reset for 1 cycle -> product=0, ready=1; no change while start=0.
- Basic multiply: 3 x 5 with a one-cycle start -> ready=0 for 16 cycles, then ready=1 and product=0x0000000F.
- Max values: 0xFFFF x 0xFFFF -> product=0xFFFE0001 exactly 16 edges after the start edge. Also 0 x 0xABCD -> product=0 with the same fixed latency.
- Mixed value with operand churn: 0x1234 x 0x5678, with the inputs randomized during BUSY and a second start pulse mid-operation -> product=0x06260060 and the second start has no effect.
- Reset mid-operation: start 0x00FF x 0x0100, assert reset at iteration 8 -> product=0 and ready=1 on the next edge. A following start of 7 x 6 yields 0x0000002A.
- Back-to-back and random: hold start high, 200 random operand pairs -> each result equals the unsigned reference product and each completion is 16 edges after acceptance.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing for the shift-add sequential multiplier.
package seq_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter must hold values 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_mult_datapath.sv
// A/B shift registers, accumulator adder and product register for seq_multiplier.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               done,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    product_q;
  logic [PW-1:0]    sum_c;

  // Partial-product add for the current multiplier bit.
  assign sum_c = acc_q + (b_q[0] ? a_q : PW'(0));

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else if (load) begin
      a_q   <= PW'(multiplicand);
      b_q   <= multiplier;
      acc_q <= '0;
    end else if (step) begin
      acc_q <= sum_c;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      if (done) begin
        product_q <= sum_c;
      end
    end
  end

  assign product = product_q;

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned radix-2 shift-add multiplier with ready/start handshake and fixed WIDTH-cycle latency.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               ready
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             load, step, done;

  // State, iteration counter and registered ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      if (load) begin
        cnt_q <= '0;
      end else if (step) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state and datapath controls; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .done         (done),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product)
  );

  assign ready = ready_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed vector table, corner sequences, random back-to-back.
module tb_seq_multiplier;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 16;
  localparam int          BOUND = 40;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [W-1:0]    multiplicand;
  logic [W-1:0]    multiplier;
  logic [2*W-1:0]  product;
  logic            ready;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] last_prod = '0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .ready        (ready)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    logic           churn;
    string          name;
  } vec_t;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return (2*W)'(p);
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Issue one operation from IDLE and follow it to completion.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input logic churn, input string name);
    int   k;
    logic hold_err;
    hold_err = 1'b0;
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, 32'(ready), 32'd0);
    k = 0;
    while (!ready && k < BOUND) begin
      if (product !== last_prod) hold_err = 1'b1;
      if (churn) begin
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        start        = (k == 5);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({name, "_latency"}, 32'(k), 32'(LAT));
    check({name, "_product"}, product, exp);
    check({name, "_hold"}, 32'(hold_err), 32'd0);
    last_prod = exp;
  endtask

  vec_t vecs[5];

  initial begin
    int k;
    int ok_lat;
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] rexp;

    vecs[0] = '{16'd3,    16'd5,    32'h0000000F, 1'b0, "mul_3x5"};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, "mul_max"};
    vecs[2] = '{16'h0000, 16'hABCD, 32'h00000000, 1'b0, "mul_zero"};
    vecs[3] = '{16'h8000, 16'h0002, 32'h00010000, 1'b0, "mul_msb"};
    vecs[4] = '{16'h1234, 16'h5678, 32'h06260060, 1'b1, "mul_churn"};

    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    @(negedge clk);
    reset = 1'b0;
    check("reset_product", product, 32'd0);
    check("reset_ready", 32'(ready), 32'd1);
    repeat (3) @(negedge clk);
    check("idle_product", product, 32'd0);
    check("idle_ready", 32'(ready), 32'd1);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].churn, vecs[i].name);

    // Abort after 8 iterations; product must clear even though it held a result.
    @(negedge clk);
    start = 1'b1; multiplicand = 16'h00FF; multiplier = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 8; k++) @(negedge clk);
    check("abort_busy", 32'(ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_product", product, 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    last_prod = '0;

    run_op(16'd7, 16'd6, 32'h0000002A, 1'b0, "post_abort");

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; multiplicand = 16'd9; multiplier = 16'd9;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_prio_ready", 32'(ready), 32'd1);
    check("rst_prio_product", product, 32'd0);
    @(negedge clk);
    check("rst_prio_idle", 32'(ready), 32'd1);

    // Start held high: each op accepted on the edge after ready rises.
    ok_lat = 1;
    start  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      if (i % 17 == 0) ra = '1;
      if (i % 23 == 0) rb = '0;
      multiplicand = ra; multiplier = rb;
      rexp = ref_mul(ra, rb);
      @(negedge clk);
      if (ready) begin
        check("b2b_accept", 32'(ready), 32'd0);
        break;
      end
      k = 0;
      while (!ready && k < BOUND) begin
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        @(negedge clk);
        k++;
      end
      if (k != LAT) ok_lat = 0;
      check($sformatf("b2b_product_%0d", i), product, rexp);
      if (k >= BOUND) break;
    end
    start = 1'b0;
    check("b2b_latency_all", 32'(ok_lat), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
